// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default raster constants, totals and the coordinate type shared by the VGA timing slice
package vga_timing_pkg;
    typedef logic [9:0] coord_t;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int H_TOTAL    = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL    = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster outputs bundle (coordinates, blank, syncs, pulses, frame count)
//   master: driven by vga_timing_gen; slave: consumed by drawers / game logic
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
);
    coord_t                 DrawX;
    coord_t                 DrawY;
    logic                   blank;
    logic                   hs;
    logic                   vs;
    logic                   line_start;
    logic                   frame_start;
    logic                   vblank_start;
    logic [FRAME_CNT_W-1:0] frame_count;
    modport master (output DrawX, DrawY, blank, hs, vs, line_start, frame_start, vblank_start, frame_count);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, vblank_start, frame_count);
endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register, async active-low reset to RESET_VAL; DEPTH 0 is a wire
//   clk, rst_n : clock and async active-low reset
//   i_d / o_q  : input bit / input delayed by DEPTH clocks
module vga_sync_delay #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst_n};
        assign o_q = i_d;
    end else begin : g_shift
        logic [DEPTH-1:0] r_sr;
        // Truncating the concatenation drops the oldest bit, which also covers DEPTH == 1.
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r_sr <= {DEPTH{RESET_VAL}};
            else r_sr <= DEPTH'({r_sr, i_d});
        assign o_q = r_sr[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, active/sync decode, event pulses and frame counter
//   vga_clk : pixel clock
//   reset_n : async active-low reset
//   vga     : master side of vga_timing_gen_if (DrawX/DrawY, blank, hs/vs, pulses, frame_count)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_D,
    parameter int H_FP        = H_FP_D,
    parameter int H_SYNC      = H_SYNC_D,
    parameter int H_BP        = H_BP_D,
    parameter int V_ACTIVE    = V_ACTIVE_D,
    parameter int V_FP        = V_FP_D,
    parameter int V_SYNC      = V_SYNC_D,
    parameter int V_BP        = V_BP_D,
    parameter int SYNC_DELAY  = 2,
    parameter int FRAME_CNT_W = 16
) (
    input logic              vga_clk,
    input logic              reset_n,
    vga_timing_gen_if.master vga
);
    localparam int     H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);
    localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H/V totals must not exceed 1024");
    end

    coord_t                 r_x;
    coord_t                 r_y;
    logic                   r_blank;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic                   r_vblank_start;
    logic                   r_hs_raw;
    logic                   r_vs_raw;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    coord_t                 w_x_next;
    coord_t                 w_y_next;
    logic                   w_line_start;
    logic                   w_frame_start;

    assign w_x_next      = (r_x == H_LAST) ? '0 : r_x + 10'd1;
    assign w_y_next      = (r_x != H_LAST) ? r_y : (r_y == V_LAST) ? '0 : r_y + 10'd1;
    assign w_line_start  = w_x_next == '0;
    assign w_frame_start = w_line_start && w_y_next == '0;

    // Everything is decoded from the next-state counters so the registered flags line up
    // with the registered coordinates on the same cycle.
    always_ff @(posedge vga_clk or negedge reset_n)
        if (!reset_n) begin
            r_x            <= '0;
            r_y            <= '0;
            r_blank        <= 1'b0;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_hs_raw       <= 1'b1;
            r_vs_raw       <= 1'b1;
            r_frame_count  <= '0;
        end else begin
            r_x            <= w_x_next;
            r_y            <= w_y_next;
            r_blank        <= w_x_next < H_ACT && w_y_next < V_ACT;
            r_line_start   <= w_line_start;
            r_frame_start  <= w_frame_start;
            r_vblank_start <= w_line_start && w_y_next == V_ACT;
            r_hs_raw       <= !(w_x_next >= HS_BEG && w_x_next < HS_END);
            r_vs_raw       <= !(w_y_next >= VS_BEG && w_y_next < VS_END);
            r_frame_count  <= r_frame_count + FRAME_CNT_W'(w_frame_start);
        end

    vga_sync_delay #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_hs_delay (
        .clk(vga_clk), .rst_n(reset_n), .i_d(r_hs_raw), .o_q(vga.hs)
    );
    vga_sync_delay #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_vs_delay (
        .clk(vga_clk), .rst_n(reset_n), .i_d(r_vs_raw), .o_q(vga.vs)
    );

    assign vga.DrawX        = r_x;
    assign vga.DrawY        = r_y;
    assign vga.blank        = r_blank;
    assign vga.line_start   = r_line_start;
    assign vga.frame_start  = r_frame_start;
    assign vga.vblank_start = r_vblank_start;
    assign vga.frame_count  = r_frame_count;
endmodule
